// File: rtl/nes_controller_emulator.sv
`timescale 1ns/1ps
// nes_controller_emulator
//   Pad-side responder for the NES/SNES latch/clock serial protocol. Behaves
//   like a 4021 shift-register pad: while the host holds latch high the
//   parallel button state is loaded continuously. Once latch drops, each
//   rising edge of the host clock presents the next button on the data line.
//   Host pins are asynchronous, so each pin is synchronised and glitch
//   filtered before any edge is acted upon.
//
// Parameters
//   NUM_BITS      bits per poll (8 = NES, 16 = SNES, at most 16)
//   SYNC_STAGES   synchroniser depth on both host pins (at least 2)
//   FILTER_CYCLES consecutive differing synced samples needed to flip a level
//   FILL_LEVEL    data level driven after all NUM_BITS have been shifted out
//
// Ports
//   i_clk          system clock
//   i_rst_n        asynchronous reset, active low
//   i_buttons      button state, 1 = pressed, bit0 = A (synchronous to i_clk)
//   i_nes_latch    host latch, asynchronous, active high
//   i_nes_clk      host shift clock, asynchronous, idles high
//   o_nes_data     serial data, active low (pressed drives 0)
//   o_poll_strobe  one-cycle pulse when an accepted latch falling edge starts a poll
//   o_shift_active high while bits are being shifted out
//   o_bit_index    bits shifted since the last latch, saturates at NUM_BITS
module nes_controller_emulator #(
  parameter int NUM_BITS      = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 2,
  parameter bit FILL_LEVEL    = 1'b0
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [NUM_BITS-1:0] i_buttons,
  input  logic                i_nes_latch,
  input  logic                i_nes_clk,
  output logic                o_nes_data,
  output logic                o_poll_strobe,
  output logic                o_shift_active,
  output logic [4:0]          o_bit_index
);

  localparam int         CW         = $clog2(FILTER_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [4:0] LAST_INDEX = 5'(NUM_BITS - 1);

  // Channel 0 is latch (idles low), channel 1 is the host clock (idles high).
  localparam logic [1:0] IDLE_LEVELS = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LATCHED,
    S_SHIFTING,
    S_DONE
  } state_t;

  logic [1:0]                  w_pins;
  logic [1:0][SYNC_STAGES-1:0] r_sync;
  logic [1:0]                  r_filt;
  logic [1:0][CW-1:0]          r_cnt;
  logic                        r_clkPrev;
  logic                        w_latch;
  logic                        w_clkRise;

  state_t                      r_state;
  state_t                      w_nextState;
  logic                        w_load;
  logic                        w_shift;
  logic                        w_strobe;
  logic                        w_lastShift;

  logic [NUM_BITS-1:0]         r_shreg;
  logic [4:0]                  r_bitIndex;
  logic                        r_data;
  logic                        r_pollStrobe;

  assign w_pins = {i_nes_clk, i_nes_latch};

  // Synchroniser chain plus glitch filter per pin. The filtered level only
  // moves after FILTER_CYCLES back-to-back synced samples disagree with it;
  // any agreeing sample restarts the count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync[0] <= '0;
      r_sync[1] <= '1;
      r_filt    <= IDLE_LEVELS;
      r_cnt     <= '0;
      r_clkPrev <= 1'b1;
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        r_sync[ch] <= {r_sync[ch][SYNC_STAGES-2:0], w_pins[ch]};
        if (r_sync[ch][SYNC_STAGES-1] != r_filt[ch]) begin
          if (r_cnt[ch] == CNT_LAST) begin
            r_filt[ch] <= ~r_filt[ch];
            r_cnt[ch]  <= '0;
          end else begin
            r_cnt[ch] <= r_cnt[ch] + CNT_ONE;
          end
        end else begin
          r_cnt[ch] <= '0;
        end
      end
      r_clkPrev <= r_filt[1];
    end
  end

  assign w_latch     = r_filt[0];
  assign w_clkRise   = r_filt[1] & ~r_clkPrev;
  assign w_lastShift = (r_bitIndex == LAST_INDEX);

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and control decode. A high latch overrides everything,
  // including a host clock edge arriving in the same cycle.
  always_comb begin
    w_nextState = r_state;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_strobe    = 1'b0;
    if (w_latch) begin
      w_nextState = S_LATCHED;
      w_load      = 1'b1;
    end else begin
      case (r_state)
        S_LATCHED: begin
          w_nextState = S_SHIFTING;
          w_strobe    = 1'b1;
        end
        S_SHIFTING: begin
          if (w_clkRise) begin
            w_shift = 1'b1;
            if (w_lastShift) begin
              w_nextState = S_DONE;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Shift register and registered data line. The register holds inverted
  // buttons so its LSB is directly the active-low level to present.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shreg      <= '1;
      r_bitIndex   <= '0;
      r_data       <= 1'b1;
      r_pollStrobe <= 1'b0;
    end else begin
      r_pollStrobe <= w_strobe;
      if (w_load) begin
        r_shreg    <= ~i_buttons;
        r_bitIndex <= '0;
        r_data     <= ~i_buttons[0];
      end else if (w_shift) begin
        r_shreg    <= {FILL_LEVEL, r_shreg[NUM_BITS-1:1]};
        r_bitIndex <= r_bitIndex + 5'd1;
        r_data     <= w_lastShift ? FILL_LEVEL : r_shreg[1];
      end
    end
  end

  assign o_nes_data     = r_data;
  assign o_poll_strobe  = r_pollStrobe;
  assign o_shift_active = (r_state == S_SHIFTING);
  assign o_bit_index    = r_bitIndex;

endmodule

// File: tb/tb_nes_controller_emulator.sv
`timescale 1ns/1ps
// Testbench for nes_controller_emulator. An NES (8-bit) and an SNES (16-bit)
// instance share the host pins so every poll exercises both widths.
module tb_nes_controller_emulator;

  logic        clk;
  logic        rst_n;
  logic [15:0] buttons;
  logic        nesLatch;
  logic        nesClk;
  logic        data8, strobe8, active8;
  logic [4:0]  idx8;
  logic        data16, strobe16, active16;
  logic [4:0]  idx16;

  int          tests;
  int          fails;
  int          strobeCnt8;
  int          strobeCnt16;
  logic [31:0] s8;
  logic [31:0] s16;

  typedef struct {
    logic [15:0] btn;
    int          pulses;
    logic [31:0] exp8;
    logic [4:0]  idx8;
    logic        data8;
    logic [31:0] exp16;
    logic [4:0]  idx16;
    logic        data16;
  } vec_t;

  vec_t vecs[6];

  nes_controller_emulator #(.NUM_BITS(8)) dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_buttons(buttons[7:0]),
    .i_nes_latch(nesLatch), .i_nes_clk(nesClk),
    .o_nes_data(data8), .o_poll_strobe(strobe8),
    .o_shift_active(active8), .o_bit_index(idx8)
  );

  nes_controller_emulator #(.NUM_BITS(16)) dut16 (
    .i_clk(clk), .i_rst_n(rst_n), .i_buttons(buttons),
    .i_nes_latch(nesLatch), .i_nes_clk(nesClk),
    .o_nes_data(data16), .o_poll_strobe(strobe16),
    .o_shift_active(active16), .o_bit_index(idx16)
  );

  always #5 clk = ~clk;

  // Strobe is a full-cycle pulse, so each one is seen on exactly one negedge.
  always @(negedge clk) begin
    if (strobe8)  strobeCnt8  <= strobeCnt8 + 1;
    if (strobe16) strobeCnt16 <= strobeCnt16 + 1;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Host latch sequence: hold high long enough to load, then release.
  task automatic latchPhase(input logic [15:0] btn);
    buttons  = btn;
    nesLatch = 1'b1;
    tick(12);
    nesLatch = 1'b0;
    tick(8);
  endtask

  // Host clock pulses, 6 clks low then 6 high; data sampled just before each rise.
  task automatic clockPulses(input int n);
    for (int k = 0; k < n; k++) begin
      nesClk = 1'b0;
      tick(6);
      s8[k]  = data8;
      s16[k] = data16;
      nesClk = 1'b1;
      tick(6);
    end
  endtask

  function automatic logic [31:0] pulseMask(input int p);
    return (p >= 32) ? 32'hFFFF_FFFF : ((32'd1 << p) - 32'd1);
  endfunction

  // Reference: a pad presents inverted buttons LSB first, then the fill level.
  function automatic logic modelBit(input logic [15:0] btn, input int n, input int k);
    return (k < n) ? ~btn[k] : 1'b0;
  endfunction

  function automatic logic [31:0] modelStream(input logic [15:0] btn, input int n, input int p);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < p; k++) r[k] = modelBit(btn, n, k);
    return r;
  endfunction

  task automatic applyStimulus(input vec_t v, input string tag);
    int base8, base16;
    base8  = strobeCnt8;
    base16 = strobeCnt16;
    s8  = '0;
    s16 = '0;
    latchPhase(v.btn);
    checkOutput({tag, " strobe8"}, 32'(strobeCnt8 - base8), 32'd1);
    checkOutput({tag, " strobe16"}, 32'(strobeCnt16 - base16), 32'd1);
    clockPulses(v.pulses);
    checkOutput({tag, " stream8"}, s8 & pulseMask(v.pulses), v.exp8);
    checkOutput({tag, " stream16"}, s16 & pulseMask(v.pulses), v.exp16);
    checkOutput({tag, " idx8"}, 32'(idx8), 32'(v.idx8));
    checkOutput({tag, " idx16"}, 32'(idx16), 32'(v.idx16));
    checkOutput({tag, " data8"}, 32'(data8), 32'(v.data8));
    checkOutput({tag, " data16"}, 32'(data16), 32'(v.data16));
  endtask

  initial begin
    logic        done;
    logic [15:0] held;
    logic [4:0]  maxIdx;
    int          base8;
    vec_t        rv;

    tests = 0; fails = 0; strobeCnt8 = 0; strobeCnt16 = 0;
    clk = 1'b0; rst_n = 1'b0; nesLatch = 1'b0; nesClk = 1'b1; buttons = '0;
    s8 = '0; s16 = '0;

    vecs[0] = '{16'h0081,  8, 32'h7E,  5'd8, 1'b0, 32'h7E,   5'd8,  1'b1};
    vecs[1] = '{16'hA5C3, 17, 32'h3C,  5'd8, 1'b0, 32'h5A3C, 5'd16, 1'b0};
    vecs[2] = '{16'h0002,  3, 32'h5,   5'd3, 1'b1, 32'h5,    5'd3,  1'b1};
    vecs[3] = '{16'hFFFF,  9, 32'h0,   5'd8, 1'b0, 32'h0,    5'd9,  1'b0};
    vecs[4] = '{16'h0000,  0, 32'h0,   5'd0, 1'b1, 32'h0,    5'd0,  1'b1};
    vecs[5] = '{16'h8000, 16, 32'hFF,  5'd8, 1'b0, 32'h7FFF, 5'd16, 1'b0};

    // Reset then idle pins: outputs stay at reset values.
    tick(3);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      checkOutput("idle data", 32'(data8), 32'd1);
      checkOutput("idle strobe", 32'(strobe8 | strobe16), 32'd0);
      checkOutput("idle idx", 32'(idx8 | idx16), 32'd0);
    end
    // Host clock edges before any latch are ignored.
    clockPulses(3);
    checkOutput("idle clk idx", 32'(idx8), 32'd0);
    checkOutput("idle clk data", 32'(data8), 32'd1);

    // Directed vector table.
    for (int i = 0; i < 6; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

    // Glitch rejection mid-stream.
    latchPhase(16'h0081);
    clockPulses(3);
    base8 = strobeCnt8;
    nesClk = 1'b0; tick(1); nesClk = 1'b1; tick(8);
    checkOutput("clk glitch idx", 32'(idx8), 32'd3);
    nesLatch = 1'b1; tick(1); nesLatch = 1'b0; tick(8);
    checkOutput("latch glitch idx", 32'(idx8), 32'd3);
    checkOutput("latch glitch strobe", 32'(strobeCnt8 - base8), 32'd0);
    checkOutput("latch glitch data", 32'(data8), 32'd1);

    // Latch re-asserted mid-stream; clock pulses while latch high do nothing.
    buttons = 16'h0002;
    nesLatch = 1'b1;
    tick(12);
    clockPulses(2);
    checkOutput("relatch idx", 32'(idx8), 32'd0);
    checkOutput("relatch data", 32'(data8), 32'd1);
    checkOutput("relatch active", 32'(active8), 32'd0);
    nesLatch = 1'b0;
    tick(8);
    s8 = '0;
    clockPulses(8);
    checkOutput("relatch stream", s8 & 32'hFF, 32'hFD);

    // Buttons churn while shifting; stream must reflect value at latch fall.
    held = 16'h3A96;
    latchPhase(held);
    s8 = '0; s16 = '0;
    done = 1'b0;
    fork
      begin clockPulses(16); done = 1'b1; end
      begin while (!done) begin @(negedge clk); buttons = 16'($urandom); end end
    join
    checkOutput("churn stream8", s8 & 32'hFFFF, modelStream(held, 8, 16));
    checkOutput("churn stream16", s16 & 32'hFFFF, modelStream(held, 16, 16));

    // Latch rise coincident with host clock rise: no shift occurs.
    latchPhase(16'h00F0);
    clockPulses(2);
    nesClk = 1'b0;
    tick(8);
    nesLatch = 1'b1;
    nesClk   = 1'b1;
    maxIdx = idx8;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (idx8 > maxIdx) maxIdx = idx8;
    end
    checkOutput("coincident max idx", 32'(maxIdx), 32'd2);
    checkOutput("coincident idx", 32'(idx8), 32'd0);
    nesLatch = 1'b0;
    tick(8);

    // Asynchronous reset mid-stream clears outputs without waiting for a clock.
    latchPhase(16'h00FF);
    clockPulses(4);
    checkOutput("pre-reset active", 32'(active8), 32'd1);
    checkOutput("pre-reset data", 32'(data8), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async rst data", 32'(data8), 32'd1);
    checkOutput("async rst idx", 32'(idx8), 32'd0);
    checkOutput("async rst active", 32'(active8), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(4);
    clockPulses(2);
    checkOutput("post-reset idx", 32'(idx8), 32'd0);
    checkOutput("post-reset data", 32'(data8), 32'd1);

    // Randomised polls against the reference model.
    for (int i = 0; i < 20; i++) begin
      rv.btn    = 16'($urandom);
      rv.pulses = $urandom_range(0, 18);
      rv.exp8   = modelStream(rv.btn, 8, rv.pulses);
      rv.exp16  = modelStream(rv.btn, 16, rv.pulses);
      rv.idx8   = 5'((rv.pulses < 8) ? rv.pulses : 8);
      rv.idx16  = 5'((rv.pulses < 16) ? rv.pulses : 16);
      rv.data8  = modelBit(rv.btn, 8, rv.pulses);
      rv.data16 = modelBit(rv.btn, 16, rv.pulses);
      applyStimulus(rv, $sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
